// File: rtl/booth_mul_ctrl_if.sv
// Decode <-> multiply sequencer handshake: MULT issue, flush, MFHI/MFLO stall
// and the architectural HI/LO outputs.
interface booth_mul_ctrl_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             mf_req;
    logic             start_ack;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op_a, op_b, flush, mf_req,
                    input  start_ack, busy, done, stall, hi, lo);
    modport slave  (input  start, op_a, op_b, flush, mf_req,
                    output start_ack, busy, done, stall, hi, lo);
endinterface

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth sequencer: signed WIDTH x WIDTH -> 2*WIDTH, one step per clock,
// result committed to HI/LO on the last step unless flushed.
module booth_mul_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_mul_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nstate;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q, m;
    logic             q_m1;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             start_ack, last, step;
    logic [WIDTH:0]   m_ext, a_sum;
    logic [2*WIDTH+1:0] shr;

    assign start_ack = bus.start & (state == IDLE || state == DONE) & ~bus.flush;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign step      = (state == RUN) & ~bus.flush;

    // A is one bit wider than M so that subtracting M = -2^(WIDTH-1) cannot overflow.
    always_comb begin
        m_ext = {m[WIDTH-1], m};
        case ({q[0], q_m1})
            2'b10:   a_sum = a - m_ext;
            2'b01:   a_sum = a + m_ext;
            default: a_sum = a;
        endcase
        shr = {a_sum[WIDTH], a_sum, q};
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (start_ack) nstate = RUN;
            RUN:  if (bus.flush) nstate = IDLE;
                  else if (last) nstate = DONE;
            DONE: nstate = start_ack ? RUN : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= nstate;
            busy_q <= (nstate == RUN);
            done_q <= (nstate == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= '0;
            q    <= '0;
            m    <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (start_ack) begin
            a    <= '0;
            q    <= bus.op_a;
            m    <= bus.op_b;
            q_m1 <= 1'b0;
            cnt  <= '0;
        end else if (step) begin
            a    <= shr[2*WIDTH+1:WIDTH+1];
            q    <= shr[WIDTH:1];
            q_m1 <= shr[0];
            cnt  <= cnt + 1'b1;
            if (last) begin
                hi_q <= shr[2*WIDTH:WIDTH+1];
                lo_q <= shr[WIDTH:1];
            end
        end
    end

    assign bus.start_ack = start_ack;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stall     = bus.mf_req & busy_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: directed table, random operands vs an
// arithmetic product model, and hand sequences for flush, back-to-back, reset.
module tb_booth_mul_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mul_ctrl_if #(.WIDTH(W)) bus();
    booth_mul_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [31:0] arch = '0;     // model of {hi,lo}

    typedef struct {
        logic [15:0] a, b;
        logic [31:0] p;
        string       nm;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] pa, pb;
        pa = 32'($signed(a));
        pb = 32'($signed(b));
        return 32'(pa * pb);
    endfunction

    // Issue a multiply with mf_req held, then track busy/stall/done until completion.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] p, input string nm);
        int lat, bcnt, scnt;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.mf_req = 1'b1;
        #1;
        chk({nm, " ack"}, 32'(bus.start_ack), 32'd1);
        chk({nm, " stall@acc"}, 32'(bus.stall), 32'd0);
        chk({nm, " old hilo@acc"}, {bus.hi, bus.lo}, arch);
        @(negedge clk);
        bus.start = 1'b0; bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
        lat = 1; bcnt = 0; scnt = 0; seen = 0;
        while (!seen && lat < 40) begin
            if (bus.done) seen = 1;
            else begin
                if (bus.busy) bcnt++;
                if (bus.stall) scnt++;
                lat++;
                @(negedge clk);
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'd17);
        chk({nm, " busy cycles"}, 32'(bcnt), 32'd16);
        chk({nm, " stall cycles"}, 32'(scnt), 32'd16);
        chk({nm, " done busy/stall"}, {30'd0, bus.busy, bus.stall}, 32'd0);
        chk({nm, " product"}, {bus.hi, bus.lo}, p);
        arch = p;
        bus.mf_req = 1'b0;
    endtask

    initial begin
        int nack, ndone, nbusy;
        logic [15:0] a, b, a2, b2;
        tbl[0] = '{16'd3,      16'd5,      32'h0000_000F, "3x5"};
        tbl[1] = '{16'hFFF9,   16'd6,      32'hFFFF_FFD6, "-7x6"};
        tbl[2] = '{16'h8000,   16'h8000,   32'h4000_0000, "minxmin"};
        tbl[3] = '{16'h7FFF,   16'h8000,   32'hC000_8000, "maxxmin"};
        tbl[4] = '{16'h0000,   16'h1234,   32'h0000_0000, "0x1234"};

        bus.start = 0; bus.op_a = 0; bus.op_b = 0; bus.flush = 0; bus.mf_req = 0;
        #12;
        chk("reset outs", {14'd0, bus.busy, bus.done, bus.hi, bus.lo}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_mul(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].nm);

        // Flush mid-RUN after 3x5 leaves 0x0000000F in hi/lo
        run_mul(16'd3, 16'd5, 32'h0000_000F, "prior");
        @(negedge clk);
        bus.start = 1; bus.op_a = 16'd100; bus.op_b = 16'd100;
        @(negedge clk); bus.start = 0;
        repeat (7) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("flush hilo", {bus.hi, bus.lo}, 32'h0000_000F);
        bus.start = 1'b1; bus.op_a = 16'd9; bus.op_b = 16'd9;
        #1;
        chk("flush blocks start", 32'(bus.start_ack), 32'd0);
        @(negedge clk);
        chk("flush+start stays idle", 32'(bus.busy), 32'd0);
        bus.start = 1'b0; bus.flush = 1'b0;
        ndone = 0;
        repeat (3) begin @(negedge clk); if (bus.done) ndone++; end
        chk("no done after flush", 32'(ndone), 32'd0);
        run_mul(16'd100, 16'd100, 32'd10000, "post-flush");

        // start held every cycle: mid-RUN starts ignored, DONE-cycle start accepted
        a = 16'hFF00; b = 16'h0123; a2 = 16'h1111; b2 = 16'hEEEE;
        @(negedge clk);
        bus.start = 1; bus.op_a = a; bus.op_b = b;
        nack = 0; nbusy = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
            #1;
            if (bus.start_ack) nack++;
            if (bus.busy) nbusy++;
        end
        chk("held start ack in RUN", 32'(nack), 32'd0);
        chk("held start busy", 32'(nbusy), 32'd16);
        @(negedge clk);
        bus.op_a = a2; bus.op_b = b2;
        #1;
        chk("b2b done", 32'(bus.done), 32'd1);
        chk("b2b ack in DONE", 32'(bus.start_ack), 32'd1);
        chk("b2b first product", {bus.hi, bus.lo}, ref_mul(a, b));
        nbusy = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
            if (bus.busy) nbusy++;
        end
        chk("b2b no bubble", 32'(nbusy), 32'd16);
        @(negedge clk);
        bus.start = 0;
        chk("b2b second done", 32'(bus.done), 32'd1);
        chk("b2b second product", {bus.hi, bus.lo}, ref_mul(a2, b2));
        arch = ref_mul(a2, b2);

        // Random operands against the arithmetic model
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (i == 0) a = 16'h8000;
            if (i == 1) b = 16'h8000;
            run_mul(a, b, ref_mul(a, b), "rand");
        end

        // Async reset between edges mid-RUN
        @(negedge clk);
        bus.start = 1; bus.op_a = 16'd77; bus.op_b = 16'd55;
        @(negedge clk); bus.start = 0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outs", {14'd0, bus.busy, bus.done, bus.hi, bus.lo}, 32'd0);
        arch = '0;
        @(negedge clk); rst_n = 1'b1;
        run_mul(16'hFFFF, 16'h7FFF, 32'hFFFF_8001, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/booth_mul_ctrl.md
Name: booth_mul_ctrl

Overview:
- Multi-cycle sequencer for signed 16x16 -> 32 radix-2 Booth multiplication in the MIPS-16 execute stage.
- Replaces the single-cycle combinational multiplier: one Booth step per clock, with the product latched into architectural HI/LO registers.
- Handshakes with decode (start/busy/done) and stalls MFHI/MFLO reads while a multiply is in flight.
- Supports pipeline flush abort.

Parameters:
- WIDTH, 16, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  MULT issue request; sampled on the rising edge.
- op_a  in  WIDTH  signed multiplier, sampled when start is accepted.
- op_b  in  WIDTH  signed multiplicand, sampled when start is accepted.
- flush  in  1  abort the in-flight multiply.
- mf_req  in  1  decode holds an MFHI/MFLO in the current cycle.
- start_ack  out  1  combinational; start is accepted this cycle.
- busy  out  1  registered; high in RUN.
- done  out  1  registered; one-cycle pulse, high in DONE.
- stall  out  1  combinational; equals mf_req & busy.
- hi  out  WIDTH  HI register, upper product half.
- lo  out  WIDTH  LO register, lower product half.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; busy=0, done=0; hi=0, lo=0.
  - Counter and datapath registers = 0.
  - Reset takes effect immediately, including mid-RUN. The partial product is discarded.
- States: IDLE, RUN, DONE.
- start_ack = start & (state==IDLE | state==DONE) & ~flush.
- On an accepted start (edge E0):
  - M <= op_b.
  - A <= 17'b0.
  - Q <= op_a.
  - q_m1 <= 0.
  - cnt <= 0.
  - state <= RUN.
- RUN, each cycle, one Booth step:
  - Examine {Q[0], q_m1}:
    - 10: A = A - sext17(M).
    - 01: A = A + sext17(M).
    - 00 or 11: A unchanged.
  - Then arithmetic shift right of the 34-bit {A,Q,q_m1} by 1, with A[16] replicated.
  - A is 17 bits so that M = -2^(WIDTH-1) never overflows.
  - cnt increments each step.
  - On the step with cnt == WIDTH-1:
    - The shifted result is written to hi/lo: {hi,lo} <= {A[15:0],Q} after the shift.
    - state <= DONE.
- Latency:
  - Start accepted at edge E0; RUN occupies the cycles after E0..E16.
  - hi/lo update at E16 (WIDTH edges after E0).
  - done=1 during the cycle following E16; busy=0 in that cycle.
- DONE:
  - Lasts exactly one cycle.
  - If start_ack, go to RUN (back-to-back, no idle bubble); otherwise go to IDLE.
- start in RUN is ignored: start_ack=0, operands are not sampled, no queuing.
- flush:
  - In RUN: state <= IDLE next edge; hi/lo keep their previous values; done is not pulsed.
  - flush with start in the same cycle: flush wins and start is not accepted.
  - In IDLE/DONE: no effect besides blocking start.
- mf_req:
  - stall=1 while busy.
  - In DONE, hi/lo already hold the new product, so stall=0.
  - mf_req in the same cycle a start is accepted: stall=0, and the read returns the old hi/lo.
- hi/lo change only at RUN completion or reset.

Test Plan:
1. Reset, then start with op_a=3, op_b=5 -> busy high for 16 cycles; done pulses on the 17th cycle after acceptance; hi=0x0000, lo=0x000F.
2. Sign and corner operands:
   - op_a=-7, op_b=6 -> hi=0xFFFF, lo=0xFFD6.
   - op_a=-32768, op_b=-32768 -> hi=0x4000, lo=0x0000.
   - op_a=32767, op_b=-32768 -> hi=0xC000, lo=0x8000.
   - op_a=0, op_b=0x1234 -> hi=lo=0.
3. Prior product 0x0000000F in hi/lo; start 100*100; flush asserted at RUN cycle 8 -> IDLE next cycle, no done pulse, hi/lo remain 0x0000/0x000F; a new start is accepted the following cycle.
4. start held every cycle:
   - Mid-RUN starts get start_ack=0 and their operands are ignored.
   - Start in the DONE cycle is accepted; the second result appears 16 cycles later with no IDLE cycle in between.
5. mf_req held from acceptance: stall=0 in the acceptance cycle, 1 for all 16 RUN cycles, 0 in DONE with hi/lo showing the new product.
6. Async reset pulse mid-RUN (between edges) -> busy, done, hi, lo go to 0 immediately, without waiting for a clock edge; after release, a new multiply completes correctly.
